transform_core_param: RTL

- Parametrised successor of the current 4x4 inverse-transform datapath.
- Takes one 16-coefficient block, already inverse-zigzagged into raster order, over a valid/ready handshake. Performs one of four modes: 4x4 IDCT with rounding, 4x4 luma-DC Hadamard, 2x2 chroma-DC Hadamard, or bypass.
- Presents 16 results with output backpressure.
- Sits between the residual/dequant stage and the reconstruction adder. Replaces the fixed-width, handshake-less transform path.

---
 rtl/transform_core_param_pkg.sv | 25 ++
 rtl/transform_core_param_butterfly.sv | 25 ++
 rtl/transform_core_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/transform_core_param_pkg.sv
// Shared encodings for the parametrised 4x4 inverse-transform core.
package transform_core_param_pkg;

    localparam int NUM_LANES = 16;

    typedef enum logic [1:0] {
        MODE_IDCT4  = 2'd0,
        MODE_HAD4   = 2'd1,
        MODE_HAD2   = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Blocks that need no row/column passes go straight to the output state.
    function automatic logic single_cycle(input mode_e m, input logic all_zero);
        return all_zero || (m == MODE_HAD2) || (m == MODE_BYPASS);
    endfunction

endpackage

// File: rtl/transform_core_param_butterfly.sv
// Four-point butterfly shared by the row and column passes (IDCT or Hadamard).
module transform_butterfly_param #(
    parameter int INT_W = 22
) (
    input  logic               hadamard_sel,
    input  logic [4*INT_W-1:0] x,
    output logic [4*INT_W-1:0] y
);

    logic signed [INT_W-1:0] x0, x1, x2, x3;
    logic signed [INT_W-1:0] e0, e1, e2, e3;

    assign x0 = x[0*INT_W +: INT_W];
    assign x1 = x[1*INT_W +: INT_W];
    assign x2 = x[2*INT_W +: INT_W];
    assign x3 = x[3*INT_W +: INT_W];

    assign e0 = x0 + x2;
    assign e1 = x0 - x2;
    assign e2 = hadamard_sel ? (x1 - x3) : ((x1 >>> 1) - x3);
    assign e3 = hadamard_sel ? (x1 + x3) : (x1 + (x3 >>> 1));

    assign y = {e0 - e3, e1 - e2, e1 + e2, e0 + e3};

endmodule

// File: rtl/transform_core_param.sv
// 4x4 inverse transform (IDCT4 / HAD4 / HAD2 / bypass) with valid/ready on both sides.
module transform_core_param
    import transform_core_param_pkg::*;
#(
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 16,
    parameter int RES_W   = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_mode,
    input  logic                           in_all_zero,
    input  logic [NUM_LANES*COEFF_W-1:0]   in_coeff,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_mode,
    output logic [NUM_LANES*OUT_W-1:0]     out_res
);

    localparam int INT_W = COEFF_W + 6;

    localparam logic signed [INT_W-1:0] OUT_MAX = INT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [INT_W-1:0] OUT_MIN = ~OUT_MAX;
    localparam logic signed [INT_W-1:0] RES_MAX = INT_W'((64'sd1 <<< (RES_W - 1)) - 64'sd1);
    localparam logic signed [INT_W-1:0] RES_MIN = ~RES_MAX;

    state_e                             state;
    logic [1:0]                         cnt;
    mode_e                              mode_q;
    logic [NUM_LANES-1:0][INT_W-1:0]    work;

    logic                               accept;
    logic [4*INT_W-1:0]                 bf_x;
    logic [4*INT_W-1:0]                 bf_y;

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [INT_W-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
        if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    // Round by 1/64, clip to the residual range, then sign-extend to the lane width.
    function automatic logic [OUT_W-1:0] clip_res(input logic signed [INT_W-1:0] v);
        logic signed [INT_W-1:0] r;
        logic signed [RES_W-1:0] c;
        r = (v + INT_W'(32)) >>> 6;
        if (r > RES_MAX)      c = RES_MAX[RES_W-1:0];
        else if (r < RES_MIN) c = RES_MIN[RES_W-1:0];
        else                  c = r[RES_W-1:0];
        return OUT_W'(c);
    endfunction

    // rst_n gates in_ready so nothing is offered as accepted while held in reset.
    assign in_ready  = rst_n & ena & ((state == ST_IDLE) | ((state == ST_OUT) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_OUT);
    assign out_mode  = mode_q;

    always_comb begin
        bf_x = '0;
        for (int i = 0; i < 4; i++) begin
            if (state == ST_COL) bf_x[i*INT_W +: INT_W] = work[{2'(i), cnt}];
            else                 bf_x[i*INT_W +: INT_W] = work[{cnt, 2'(i)}];
        end
    end

    transform_butterfly_param #(.INT_W(INT_W)) u_bfly (
        .hadamard_sel (mode_q == MODE_HAD4),
        .x            (bf_x),
        .y            (bf_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 2'd0;
            mode_q <= MODE_IDCT4;
            work   <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE, ST_OUT: begin
                    if (accept) begin
                        mode_q <= mode_e'(in_mode);
                        cnt    <= 2'd0;
                        for (int k = 0; k < NUM_LANES; k++)
                            work[k] <= in_all_zero ? '0
                                     : INT_W'(signed'(in_coeff[k*COEFF_W +: COEFF_W]));
                        state  <= single_cycle(mode_e'(in_mode), in_all_zero) ? ST_OUT : ST_ROW;
                    end else if (state == ST_OUT && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ROW: begin
                    for (int i = 0; i < 4; i++)
                        work[{cnt, 2'(i)}] <= bf_y[i*INT_W +: INT_W];
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= ST_COL;
                end
                ST_COL: begin
                    for (int i = 0; i < 4; i++)
                        work[{2'(i), cnt}] <= bf_y[i*INT_W +: INT_W];
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= ST_OUT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // 2x2 chroma DC Hadamard taken from raster lanes 0,1,4,5.
    logic signed [INT_W-1:0] ha, hb, hc, hd;
    logic signed [INT_W-1:0] h0, h1, h4, h5;

    always_comb begin
        ha = work[0];
        hb = work[1];
        hc = work[4];
        hd = work[5];
        h0 = ha + hb + hc + hd;
        h1 = ha - hb + hc - hd;
        h4 = ha + hb - hc - hd;
        h5 = ha - hb - hc + hd;
    end

    always_comb begin
        out_res = '0;
        if (state == ST_OUT) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                case (mode_q)
                    MODE_IDCT4: out_res[k*OUT_W +: OUT_W] = clip_res(work[k]);
                    MODE_HAD2: begin
                        case (k)
                            0:       out_res[k*OUT_W +: OUT_W] = sat_out(h0);
                            1:       out_res[k*OUT_W +: OUT_W] = sat_out(h1);
                            4:       out_res[k*OUT_W +: OUT_W] = sat_out(h4);
                            5:       out_res[k*OUT_W +: OUT_W] = sat_out(h5);
                            default: out_res[k*OUT_W +: OUT_W] = '0;
                        endcase
                    end
                    default:    out_res[k*OUT_W +: OUT_W] = sat_out(work[k]);
                endcase
            end
        end
    end

endmodule
